uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - UART receiver, 8N1 by default, 16x oversampling; consumes the 1-clk 'tick' strobe from the baud generator.
// - Resynchronises the serial line, validates the start bit, shifts in DBIT data bits LSB first and checks the stop bit.
// - Holds each received byte in an output register with a valid/acknowledge handshake and sticky overrun/framing flags.
// - Sits between the pad-side rx pin and the SDRAM-tester command parser.
// PARAMETERS
// - DBIT     8   number of data bits per frame (5..9)
// - SB_TICK  16  ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// PORTS
// - clk           in   1     system clock, all logic on rising edge
// - reset_n       in   1     asynchronous reset, active-low
// - rx            in   1     serial input, asynchronous to clk, idle high
// - tick          in   1     16x baud strobe, one clk wide
// - rd_ack        in   1     consumer has taken dout; clears rx_valid
// - dout          out  DBIT  last received data word
// - rx_valid      out  1     dout holds an unread word
// - rx_done_tick  out  1     1-clk pulse when a frame completes
// - frame_err     out  1     stop bit of the word in dout sampled low
// - overrun       out  1     sticky: a word arrived while rx_valid=1 and no rd_ack
// BEHAVIOUR
// - Reset (reset_n=0, async): state=IDLE, s=0, n=0, shift=0, both sync flops=1.
//   Outputs: dout=0, rx_valid=0, rx_done_tick=0, frame_err=0, overrun=0.
// - Input sync: 2-flop chain, output rx_s; 2-clk latency. All sampling uses rx_s, never rx.
// - Counters: s is 5 bits (tick count within a bit, covers SB_TICK up to 32); n counts 0..DBIT-1.
// - FSM, all state changes except IDLE->START are qualified by tick:
//   IDLE:  rx_s==0 -> START, s=0. No tick needed.
//   START: on tick, if s==7:
//            rx_s==0 -> DATA, s=0, n=0.
//            rx_s==1 -> IDLE (glitch reject, no pulse, no flags).
//          else s++.
//   DATA:  on tick, if s==15: s=0, shift={rx_s, shift[DBIT-1:1]}.
//            If n==DBIT-1 -> STOP, else n++.
//          else s++.
//   STOP:  on tick, if s==SB_TICK-1: -> IDLE, complete frame. else s++.
// - Frame complete (same clk as STOP->IDLE):
//   - rx_done_tick=1 for exactly that clk.
//   - dout<=shift; frame_err<=~rx_s. The word is stored even on a framing error.
// - Handshake:
//   - complete & ~rx_valid -> rx_valid<=1.
//   - rd_ack & ~complete -> rx_valid<=0, overrun<=0.
//   - complete & rx_valid & ~rd_ack -> dout overwritten, rx_valid stays 1, overrun<=1.
//   - complete & rd_ack same clk -> rx_valid=1, new word loaded, overrun<=0.
//   - rd_ack with rx_valid=0 -> no effect.
// - A tick arriving while in IDLE is ignored. A tick and a falling rx_s in the same clk: IDLE->START, s=0.
// - rx low for a whole frame (break): frame completes with dout=0, frame_err=1, then FSM re-enters START next clk.
// - Asserting reset mid-frame aborts immediately; the partial word is lost, no pulse.
// - Start-edge to rx_done_tick latency: 2 (sync) + clk of tick #(8+16*DBIT+SB_TICK) after the edge.
// STRUCTURE
// - Package uart_pkg:
//   - state enum IDLE/START/DATA/STOP, 2-bit binary encoding.
//   - Constants OVERSAMPLE=16 and MID_SAMPLE=7.
//   - Default DBIT and SB_TICK.
// - One sub-module, uart_rx_sync: 2-flop synchroniser, reset value 1, shared with future ports.
// - The FSM and the output/handshake register stay in uart_rx.
// TESTING
// - Clock 10 MHz, tick every 5 clk (baud-gen M=5), 1 bit = 80 clk.
// - T1: send 0x55 with stop=1 -> one rx_done_tick, dout=0x55, rx_valid=1, frame_err=0, overrun=0.
// - T2: rx low pulse of 40 clk then high -> returns to IDLE, no rx_done_tick, all outputs unchanged.
// - T3: send 0xA3 with stop bit forced 0 -> dout=0xA3, frame_err=1, rx_valid=1.
// - T4: send 0x11 then 0x22, no rd_ack -> dout=0x22, rx_valid=1, overrun=1; next rd_ack -> rx_valid=0, overrun=0.
// - T5: rd_ack asserted in the same clk as the 0x7E completion -> rx_valid=1, dout=0x7E, overrun=0.
// - T6: reset_n low at data bit 4 of 0xF0, release, then send 0x0F -> only dout=0x0F reported; outputs are 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the FSM state encoding, oversampling constants and frame defaults.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Ports: clk, reset_n (async, active-low), d (async in), q (synchronised out).
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to 1 so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, DBIT data bits LSB first, SB_TICK stop ticks.
// Ports: clk, reset_n, rx (serial in), tick (16x baud strobe), rd_ack (word taken);
//        dout (data), rx_valid, rx_done_tick (frame pulse), frame_err, overrun.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            tick,
    input  logic            rd_ack,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun
);

    localparam int NW = $clog2(DBIT);

    localparam logic [4:0]    S_MID  = 5'(MID_SAMPLE);
    localparam logic [4:0]    S_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    state_t          state;
    logic [4:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            complete;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Last stop tick: the frame finishes on this clock edge.
    assign complete = (state == STOP) && tick && (s == S_STOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            shift <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Start edge needs no tick; s counts from the edge.
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            // Mid start bit: still low means a real frame.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n == N_LAST)
                                state <= STOP;
                            else
                                n <= n + 1'b1;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP)
                            state <= IDLE;
                        else
                            s <= s + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output word register and valid/ack handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= complete;
            if (complete) begin
                // Word is kept even when the stop bit is bad.
                dout      <= shift;
                frame_err <= ~rx_s;
                rx_valid  <= 1'b1;
                if (rd_ack)
                    overrun <= 1'b0;
                else if (rx_valid)
                    overrun <= 1'b1;
            end else if (rd_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
